// File: rtl/mw_controller.sv
// Microwave cooking-sequence controller.
// Drives the MM:SS countdown timer (load / clear / count-enable), generates the
// countdown tick, the magnetron drive and the end-of-cook beeper.
// Every output is a register, so each one reflects the decision made on the
// previous rising clock edge.
module mw_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int BEEP_CYCLES = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEEP_CYCLES > 0) ? $clog2(BEEP_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] beep_cnt_q;
    logic          key_prev_q, start_prev_q, stop_prev_q;
    logic          loadn_q, clrn_q, enable_q, mag_q, beep_q;

    // Rising-edge detects; the previous-sample registers reset high so a
    // button already held through reset never looks like a fresh press.
    logic key_edge, start_edge, stop_edge;
    assign key_edge   = key_valid & ~key_prev_q;
    assign start_edge = start     & ~start_prev_q;
    assign stop_edge  = stop      & ~stop_prev_q;

    // Sequencer: state, prescaler, beep counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            beep_cnt_q   <= '0;
            key_prev_q   <= 1'b1;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            loadn_q      <= 1'b1;
            clrn_q       <= 1'b0;   // timer held clear for the whole reset
            enable_q     <= 1'b0;
            mag_q        <= 1'b0;
            beep_q       <= 1'b0;
        end else begin
            key_prev_q   <= key_valid;
            start_prev_q <= start;
            stop_prev_q  <= stop;
            // Strobes default to their idle level; each is a one-cycle pulse.
            loadn_q      <= 1'b1;
            clrn_q       <= 1'b1;
            enable_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mag_q  <= 1'b0;
                    beep_q <= 1'b0;
                    if (key_edge) begin
                        loadn_q <= 1'b0;
                        state_q <= S_SET;
                    end
                end
                S_SET: begin
                    mag_q  <= 1'b0;
                    beep_q <= 1'b0;
                    if (stop_edge) begin
                        clrn_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (start_edge && door_closed && !timer_zero) begin
                        // An accepted start swallows a coincident key press.
                        presc_q <= '0;
                        mag_q   <= 1'b1;
                        state_q <= S_COOK;
                    end else if (key_edge) begin
                        loadn_q <= 1'b0;
                    end
                end
                S_COOK: begin
                    if (timer_zero) begin
                        // Zero wins over door/stop and suppresses the tick.
                        mag_q      <= 1'b0;
                        beep_q     <= 1'b1;
                        beep_cnt_q <= '0;
                        state_q    <= S_DONE;
                    end else if (!door_closed || stop_edge) begin
                        // Prescaler is left untouched so resume keeps phase.
                        mag_q   <= 1'b0;
                        state_q <= S_PAUSE;
                    end else begin
                        mag_q <= 1'b1;
                        if (presc_q == PRESC_LAST) begin
                            presc_q  <= '0;
                            enable_q <= 1'b1;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    mag_q <= 1'b0;
                    if (stop_edge) begin
                        clrn_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (start_edge && door_closed) begin
                        mag_q   <= 1'b1;
                        state_q <= S_COOK;
                    end
                end
                S_DONE: begin
                    mag_q <= 1'b0;
                    if (stop_edge || !door_closed || beep_cnt_q == BEEP_LAST) begin
                        beep_q     <= 1'b0;
                        beep_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        beep_q     <= 1'b1;
                        beep_cnt_q <= beep_cnt_q + BW'(1);
                    end
                end
                default: begin
                    // Unused encodings fall back to a safe idle.
                    mag_q   <= 1'b0;
                    beep_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign timer_loadn  = loadn_q;
    assign timer_clrn   = clrn_q;
    assign timer_enable = enable_q;
    assign mag_on       = mag_q;
    assign beep         = beep_q;
    assign state        = state_q;

endmodule

// File: tb/tb_mw_controller.sv
// Bench for mw_controller: directed scenarios with literal expectations,
// then randomized inputs, all checked every cycle against a behavioural model.
module tb_mw_controller;

    localparam int TD = 4;
    localparam int BC = 8;

    logic clk = 1'b0;
    logic reset, key_valid, start, stop, door_closed, timer_zero;
    logic timer_loadn, timer_clrn, timer_enable, mag_on, beep;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int n_loadn = 0;

    mw_controller #(.TICK_DIV(TD), .BEEP_CYCLES(BC)) dut (
        .clock(clk), .reset(reset), .key_valid(key_valid), .start(start),
        .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_loadn(timer_loadn), .timer_clrn(timer_clrn),
        .timer_enable(timer_enable), .mag_on(mag_on), .beep(beep),
        .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode numbers follow the published state codes; the countdown tick is
    // derived from the total number of cycles actually spent cooking.
    int  m_mode = 0;
    int  m_cooked = 0;
    int  m_beeped = 0;
    bit  m_pk = 1, m_ps = 1, m_pp = 1;
    bit  e_loadn = 1, e_clrn = 0, e_en = 0, e_mag = 0, e_beep = 0;
    bit  model_ready = 0;

    initial begin
        bit ke, se, pe;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0; m_cooked = 0; m_beeped = 0;
                m_pk = 1; m_ps = 1; m_pp = 1;
                e_loadn = 1; e_clrn = 0; e_en = 0;
            end else begin
                ke = key_valid && !m_pk;
                se = start && !m_ps;
                pe = stop && !m_pp;
                e_loadn = 1; e_clrn = 1; e_en = 0;
                case (m_mode)
                    0: if (ke) begin e_loadn = 0; m_mode = 1; end
                    1: begin
                        if (pe) begin e_clrn = 0; m_mode = 0; end
                        else if (se && door_closed && !timer_zero) begin m_mode = 2; m_cooked = 0; end
                        else if (ke) e_loadn = 0;
                    end
                    2: begin
                        if (timer_zero) begin m_mode = 4; m_beeped = 0; end
                        else if (!door_closed || pe) m_mode = 3;
                        else begin
                            if (m_cooked % TD == TD - 1) e_en = 1;
                            m_cooked++;
                        end
                    end
                    3: begin
                        if (pe) begin e_clrn = 0; m_mode = 0; end
                        else if (se && door_closed) m_mode = 2;
                    end
                    default: begin
                        if (pe || !door_closed) m_mode = 0;
                        else begin
                            m_beeped++;
                            if (m_beeped == BC) m_mode = 0;
                        end
                    end
                endcase
                m_pk = key_valid; m_ps = start; m_pp = stop;
            end
            e_mag  = (m_mode == 2);
            e_beep = (m_mode == 4);
            model_ready = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [7:0] got, expv;
        forever begin
            @(negedge clk);
            if (model_ready) begin
                got  = {timer_loadn, timer_clrn, timer_enable, mag_on, beep, state};
                expv = {e_loadn, e_clrn, e_en, e_mag, e_beep, 3'(m_mode)};
                total++;
                if (got !== expv) begin
                    bad++;
                    $display("FAIL cycle_compare t=%0t got ld/cl/en/mag/bp/st=%b required %b",
                             $time, got, expv);
                end
                if (timer_loadn === 1'b0) n_loadn++;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic key_pulse();
        key_valid = 1; cyc();
        key_valid = 0; cyc();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ne, nb, n0;
        reset = 1; key_valid = 0; start = 1; stop = 0; door_closed = 1; timer_zero = 0;
        cyc();
        check("clrn_in_reset", timer_clrn, 0);
        check("state_in_reset", state, 0);
        cyc(); cyc();
        reset = 0;
        cyc();
        check("clrn_after_reset", timer_clrn, 1);
        cyc(); cyc(); cyc();
        check("held_start_no_cook", state, 0);
        check("held_start_mag", mag_on, 0);
        start = 0; cyc();

        // Three digits then start.
        n0 = n_loadn;
        key_pulse(); key_pulse(); key_pulse();
        check("three_loadn", n_loadn - n0, 3);
        check("state_set", state, 1);
        start = 1; cyc();
        check("state_cook", state, 2);
        check("mag_cook", mag_on, 1);
        start = 0;
        ne = 0;
        for (int i = 0; i < 12; i++) begin cyc(); ne += timer_enable; end
        check("enables_12cyc", ne, 3);
        timer_zero = 1; cyc();
        check("state_done", state, 4);
        check("mag_done", mag_on, 0);
        timer_zero = 0;
        nb = 0; ne = 0;
        for (int i = 0; i < 40 && state != 0; i++) begin
            nb += beep; ne += timer_enable; cyc();
        end
        check("beep_cycles", nb, BC);
        check("no_enable_done", ne, 0);
        check("idle_after_beep", state, 0);

        // Pause after two prescaler counts, then resume.
        key_pulse();
        start = 1; cyc();
        start = 0; cyc(); cyc();
        door_closed = 0; cyc();
        check("state_pause", state, 3);
        check("mag_pause", mag_on, 0);
        door_closed = 1; start = 1; cyc();
        check("state_resume", state, 2);
        start = 0; cyc();
        check("resume_en_early", timer_enable, 0);
        cyc();
        check("resume_en_2cyc", timer_enable, 1);
        door_closed = 0; cyc();
        check("state_pause2", state, 3);
        door_closed = 1; stop = 1; cyc();
        check("clrn_pause_stop", timer_clrn, 0);
        check("state_idle_stop", state, 0);
        stop = 0; cyc();
        check("clrn_one_cycle", timer_clrn, 1);

        // DONE cut short by opening the door on the third beep cycle.
        key_pulse();
        start = 1; cyc();
        start = 0; timer_zero = 1; cyc();
        timer_zero = 0;
        cyc(); cyc();
        door_closed = 0; cyc();
        check("beep_door_open", beep, 0);
        check("idle_door_open", state, 0);
        door_closed = 1; cyc();

        // Start and stop together in SET.
        key_pulse();
        start = 1; stop = 1; cyc();
        check("clrn_start_stop", timer_clrn, 0);
        check("state_start_stop", state, 0);
        check("mag_start_stop", mag_on, 0);
        start = 0; stop = 0; cyc();

        // Start refused while the timer reads zero.
        key_pulse();
        timer_zero = 1; start = 1; cyc();
        check("set_zero_start", state, 1);
        start = 0; cyc();
        check("set_zero_mag", mag_on, 0);
        timer_zero = 0; stop = 1; cyc();
        stop = 0; cyc();

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom % 500) == 0;
            key_valid   = ($urandom % 4) == 0;
            start       = ($urandom % 6) == 0;
            stop        = ($urandom % 25) == 0;
            door_closed = ($urandom % 15) != 0;
            timer_zero  = ($urandom % 30) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
